ram16x32_axil_ctrl: RTL and testbench

//  AXI4-Lite slave that owns the update port of a 16x32 dual-port lookup RAM: it turns AXI4-Lite

---
 rtl/ram16x32_axil_ctrl.sv | 277 +++++++++++++++++++++++++++
 tb/tb_ram16x32_axil_ctrl.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram16x32_axil_ctrl.sv
// AXI4-Lite slave owning the update port of a 16x32 dual-port lookup RAM.
// Writes become RAM write cycles, and reads become RAM read cycles. Partial-strobe
// writes go through a read-modify-write because the RAM has no byte enables.
// Ports:
//   axi_clk, axi_aresetn      clock, async active-low reset
//   s_axi_aw*/w*/b*           AXI4-Lite write channels
//   s_axi_ar*/r*              AXI4-Lite read channels
//   ram_wr_en/addr/wdata      RAM update-port command (registered)
//   ram_rdata                 RAM read data, valid one cycle after ram_addr with ram_wr_en=0
module ram16x32_axil_ctrl #(
    parameter int unsigned C_S_AXI_ADDR_WIDTH = 12,
    parameter int unsigned C_S_AXI_DATA_WIDTH = 32
) (
    input  logic                            axi_clk,
    input  logic                            axi_aresetn,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_awaddr,
    input  logic                            s_axi_awvalid,
    output logic                            s_axi_awready,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_wdata,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s_axi_wstrb,
    input  logic                            s_axi_wvalid,
    output logic                            s_axi_wready,
    output logic [1:0]                      s_axi_bresp,
    output logic                            s_axi_bvalid,
    input  logic                            s_axi_bready,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_araddr,
    input  logic                            s_axi_arvalid,
    output logic                            s_axi_arready,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_rdata,
    output logic [1:0]                      s_axi_rresp,
    output logic                            s_axi_rvalid,
    input  logic                            s_axi_rready,
    output logic                            ram_wr_en,
    output logic [3:0]                      ram_addr,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   ram_wdata,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   ram_rdata
);

    localparam int unsigned AW    = C_S_AXI_ADDR_WIDTH;
    localparam int unsigned DW    = C_S_AXI_DATA_WIDTH;
    localparam int unsigned SW    = DW / 8;
    localparam int unsigned IDX_W = 4;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        WR_RD,
        WR_WAIT,
        WR_WRITE,
        WR_RESP,
        RD_ISSUE,
        RD_WAIT,
        RD_RESP
    } state_e;

    state_e state_q, state_d;

    // A ready flag that is low means its one-entry buffer is occupied.
    logic             awready_q, awready_d;
    logic             wready_q, wready_d;
    logic             arready_q, arready_d;
    logic             aw_ok_q, aw_ok_d;
    logic [IDX_W-1:0] aw_idx_q, aw_idx_d;
    logic [DW-1:0]    w_data_q, w_data_d;
    logic [SW-1:0]    w_strb_q, w_strb_d;
    logic             ar_ok_q, ar_ok_d;
    logic [IDX_W-1:0] ar_idx_q, ar_idx_d;
    logic             last_wr_q, last_wr_d;

    logic [1:0]       bresp_q, bresp_d;
    logic             bvalid_q, bvalid_d;
    logic [1:0]       rresp_q, rresp_d;
    logic             rvalid_q, rvalid_d;
    logic [DW-1:0]    rdata_q, rdata_d;
    logic             ram_wr_en_q, ram_wr_en_d;
    logic [IDX_W-1:0] ram_addr_q, ram_addr_d;
    logic [DW-1:0]    ram_wdata_q, ram_wdata_d;

    logic             wr_pend_c;
    logic             rd_pend_c;
    logic             grant_wr_c;
    logic [DW-1:0]    merged_c;
    logic             unused_addr_lsbs;

    // Byte offset bits carry no information for a word-wide table.
    assign unused_addr_lsbs = ^{s_axi_awaddr[1:0], s_axi_araddr[1:0]};

    assign wr_pend_c  = !awready_q && !wready_q;
    assign rd_pend_c  = !arready_q;
    // Round-robin: on conflict, the channel not granted last time wins.
    assign grant_wr_c = wr_pend_c && (!rd_pend_c || !last_wr_q);

    // Bytewise merge of buffered write data over the old RAM word.
    always_comb begin
        merged_c = ram_rdata;
        for (int i = 0; i < int'(SW); i++) begin
            if (w_strb_q[i]) begin
                merged_c[i*8 +: 8] = w_data_q[i*8 +: 8];
            end
        end
    end

    // Channel capture, arbitration and transaction sequencing.
    always_comb begin
        state_d     = state_q;
        awready_d   = awready_q;
        wready_d    = wready_q;
        arready_d   = arready_q;
        aw_ok_d     = aw_ok_q;
        aw_idx_d    = aw_idx_q;
        w_data_d    = w_data_q;
        w_strb_d    = w_strb_q;
        ar_ok_d     = ar_ok_q;
        ar_idx_d    = ar_idx_q;
        last_wr_d   = last_wr_q;
        bresp_d     = bresp_q;
        bvalid_d    = bvalid_q;
        rresp_d     = rresp_q;
        rvalid_d    = rvalid_q;
        rdata_d     = rdata_q;
        ram_wr_en_d = 1'b0;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;

        if (s_axi_awvalid && awready_q) begin
            awready_d = 1'b0;
            aw_ok_d   = ~|s_axi_awaddr[AW-1:6];
            aw_idx_d  = s_axi_awaddr[5:2];
        end
        if (s_axi_wvalid && wready_q) begin
            wready_d = 1'b0;
            w_data_d = s_axi_wdata;
            w_strb_d = s_axi_wstrb;
        end
        if (s_axi_arvalid && arready_q) begin
            arready_d = 1'b0;
            ar_ok_d   = ~|s_axi_araddr[AW-1:6];
            ar_idx_d  = s_axi_araddr[5:2];
        end

        unique case (state_q)
            IDLE: begin
                if (grant_wr_c) begin
                    last_wr_d = 1'b1;
                    if (!aw_ok_q) begin
                        bresp_d  = RESP_SLVERR;
                        bvalid_d = 1'b1;
                        state_d  = WR_RESP;
                    end else if (w_strb_q == '0) begin
                        bresp_d  = RESP_OKAY;
                        bvalid_d = 1'b1;
                        state_d  = WR_RESP;
                    end else if (&w_strb_q) begin
                        ram_wr_en_d = 1'b1;
                        ram_addr_d  = aw_idx_q;
                        ram_wdata_d = w_data_q;
                        state_d     = WR_WRITE;
                    end else begin
                        ram_addr_d = aw_idx_q;
                        state_d    = WR_RD;
                    end
                end else if (rd_pend_c) begin
                    last_wr_d = 1'b0;
                    if (!ar_ok_q) begin
                        rresp_d  = RESP_SLVERR;
                        rdata_d  = '0;
                        rvalid_d = 1'b1;
                        state_d  = RD_RESP;
                    end else begin
                        ram_addr_d = ar_idx_q;
                        state_d    = RD_ISSUE;
                    end
                end
            end
            WR_RD: begin
                state_d = WR_WAIT;
            end
            WR_WAIT: begin
                ram_wr_en_d = 1'b1;
                ram_wdata_d = merged_c;
                state_d     = WR_WRITE;
            end
            WR_WRITE: begin
                bresp_d  = RESP_OKAY;
                bvalid_d = 1'b1;
                state_d  = WR_RESP;
            end
            WR_RESP: begin
                if (s_axi_bready) begin
                    bvalid_d  = 1'b0;
                    awready_d = 1'b1;
                    wready_d  = 1'b1;
                    state_d   = IDLE;
                end
            end
            RD_ISSUE: begin
                state_d = RD_WAIT;
            end
            RD_WAIT: begin
                rdata_d  = ram_rdata;
                rresp_d  = RESP_OKAY;
                rvalid_d = 1'b1;
                state_d  = RD_RESP;
            end
            RD_RESP: begin
                if (s_axi_rready) begin
                    rvalid_d  = 1'b0;
                    arready_d = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge axi_clk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            state_q     <= IDLE;
            awready_q   <= 1'b1;
            wready_q    <= 1'b1;
            arready_q   <= 1'b1;
            aw_ok_q     <= 1'b0;
            aw_idx_q    <= '0;
            w_data_q    <= '0;
            w_strb_q    <= '0;
            ar_ok_q     <= 1'b0;
            ar_idx_q    <= '0;
            last_wr_q   <= 1'b0;
            bresp_q     <= RESP_OKAY;
            bvalid_q    <= 1'b0;
            rresp_q     <= RESP_OKAY;
            rvalid_q    <= 1'b0;
            rdata_q     <= '0;
            ram_wr_en_q <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            awready_q   <= awready_d;
            wready_q    <= wready_d;
            arready_q   <= arready_d;
            aw_ok_q     <= aw_ok_d;
            aw_idx_q    <= aw_idx_d;
            w_data_q    <= w_data_d;
            w_strb_q    <= w_strb_d;
            ar_ok_q     <= ar_ok_d;
            ar_idx_q    <= ar_idx_d;
            last_wr_q   <= last_wr_d;
            bresp_q     <= bresp_d;
            bvalid_q    <= bvalid_d;
            rresp_q     <= rresp_d;
            rvalid_q    <= rvalid_d;
            rdata_q     <= rdata_d;
            ram_wr_en_q <= ram_wr_en_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
        end
    end

    assign s_axi_awready = awready_q;
    assign s_axi_wready  = wready_q;
    assign s_axi_arready = arready_q;
    assign s_axi_bresp   = bresp_q;
    assign s_axi_bvalid  = bvalid_q;
    assign s_axi_rresp   = rresp_q;
    assign s_axi_rvalid  = rvalid_q;
    assign s_axi_rdata   = rdata_q;
    assign ram_wr_en     = ram_wr_en_q;
    assign ram_addr      = ram_addr_q;
    assign ram_wdata     = ram_wdata_q;

endmodule

// File: tb/tb_ram16x32_axil_ctrl.sv
// Directed self-checking bench for ram16x32_axil_ctrl with a registered-read RAM model.
module tb_ram16x32_axil_ctrl;

    logic        axi_clk = 1'b0;
    logic        axi_aresetn = 1'b0;
    logic [11:0] s_axi_awaddr = '0;
    logic        s_axi_awvalid = 1'b0;
    logic        s_axi_awready;
    logic [31:0] s_axi_wdata = '0;
    logic [3:0]  s_axi_wstrb = '0;
    logic        s_axi_wvalid = 1'b0;
    logic        s_axi_wready;
    logic [1:0]  s_axi_bresp;
    logic        s_axi_bvalid;
    logic        s_axi_bready = 1'b0;
    logic [11:0] s_axi_araddr = '0;
    logic        s_axi_arvalid = 1'b0;
    logic        s_axi_arready;
    logic [31:0] s_axi_rdata;
    logic [1:0]  s_axi_rresp;
    logic        s_axi_rvalid;
    logic        s_axi_rready = 1'b0;
    logic        ram_wr_en;
    logic [3:0]  ram_addr;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata = '0;

    int checks = 0;
    int errors = 0;

    logic [31:0] mem [16];
    int          wr_count = 0;
    int          dbl_count = 0;
    logic        wr_prev = 1'b0;
    logic [3:0]  last_addr = '0;
    logic [31:0] last_data = '0;

    always #5 axi_clk = ~axi_clk;

    ram16x32_axil_ctrl #(
        .C_S_AXI_ADDR_WIDTH(12),
        .C_S_AXI_DATA_WIDTH(32)
    ) dut (
        .axi_clk      (axi_clk),
        .axi_aresetn  (axi_aresetn),
        .s_axi_awaddr (s_axi_awaddr),
        .s_axi_awvalid(s_axi_awvalid),
        .s_axi_awready(s_axi_awready),
        .s_axi_wdata  (s_axi_wdata),
        .s_axi_wstrb  (s_axi_wstrb),
        .s_axi_wvalid (s_axi_wvalid),
        .s_axi_wready (s_axi_wready),
        .s_axi_bresp  (s_axi_bresp),
        .s_axi_bvalid (s_axi_bvalid),
        .s_axi_bready (s_axi_bready),
        .s_axi_araddr (s_axi_araddr),
        .s_axi_arvalid(s_axi_arvalid),
        .s_axi_arready(s_axi_arready),
        .s_axi_rdata  (s_axi_rdata),
        .s_axi_rresp  (s_axi_rresp),
        .s_axi_rvalid (s_axi_rvalid),
        .s_axi_rready (s_axi_rready),
        .ram_wr_en    (ram_wr_en),
        .ram_addr     (ram_addr),
        .ram_wdata    (ram_wdata),
        .ram_rdata    (ram_rdata)
    );

    // Lookup RAM model: registered read, write on ram_wr_en.
    always @(posedge axi_clk) begin
        if (ram_wr_en) begin
            mem[ram_addr] <= ram_wdata;
            wr_count      <= wr_count + 1;
            last_addr     <= ram_addr;
            last_data     <= ram_wdata;
        end
        ram_rdata <= mem[ram_addr];
        wr_prev   <= ram_wr_en;
        if (wr_prev && ram_wr_en) dbl_count <= dbl_count + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Write with optional bready backpressure; lat counts clock edges after the AW/W handshake edge.
    task automatic do_write(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s,
                            input int hold, output logic [1:0] resp, output int lat);
        @(negedge axi_clk);
        s_axi_awaddr = a; s_axi_awvalid = 1'b1;
        s_axi_wdata = d;  s_axi_wstrb = s; s_axi_wvalid = 1'b1;
        @(posedge axi_clk);
        lat = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge axi_clk);
            s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
            if (s_axi_bvalid) break;
            lat++;
        end
        resp = s_axi_bresp;
        for (int i = 0; i < hold; i++) begin
            @(negedge axi_clk);
            check("bvalid_held", 32'(s_axi_bvalid), 32'd1);
            check("awready_low", 32'(s_axi_awready), 32'd0);
        end
        s_axi_bready = 1'b1;
        @(negedge axi_clk);
        s_axi_bready = 1'b0;
    endtask

    task automatic do_read(input logic [11:0] a, output logic [31:0] data,
                           output logic [1:0] resp, output int lat);
        @(negedge axi_clk);
        s_axi_araddr = a; s_axi_arvalid = 1'b1;
        @(posedge axi_clk);
        lat = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge axi_clk);
            s_axi_arvalid = 1'b0;
            if (s_axi_rvalid) break;
            lat++;
        end
        data = s_axi_rdata;
        resp = s_axi_rresp;
        s_axi_rready = 1'b1;
        @(negedge axi_clk);
        s_axi_rready = 1'b0;
    endtask

    initial begin
        logic [1:0]  resp;
        logic [31:0] data;
        int          lat;
        int          base;

        for (int i = 0; i < 16; i++) mem[i] = '0;

        // Reset values
        #12;
        check("rst_awready", 32'(s_axi_awready), 32'd1);
        check("rst_wready",  32'(s_axi_wready),  32'd1);
        check("rst_arready", 32'(s_axi_arready), 32'd1);
        check("rst_bvalid",  32'(s_axi_bvalid),  32'd0);
        check("rst_rvalid",  32'(s_axi_rvalid),  32'd0);
        check("rst_wr_en",   32'(ram_wr_en),     32'd0);
        check("rst_rdata",   s_axi_rdata,        32'd0);
        check("rst_ram_addr", 32'(ram_addr),     32'd0);
        check("rst_ram_wdata", ram_wdata,        32'd0);
        check("rst_bresp_rresp", 32'({s_axi_bresp, s_axi_rresp}), 32'd0);
        @(negedge axi_clk);
        axi_aresetn = 1'b1;
        repeat (2) @(negedge axi_clk);

        // T5: simultaneous write and read after reset; write wins, bready held low 5 cycles
        s_axi_awaddr = 12'h004; s_axi_awvalid = 1'b1;
        s_axi_wdata = 32'h12345678; s_axi_wstrb = 4'hF; s_axi_wvalid = 1'b1;
        s_axi_araddr = 12'h004; s_axi_arvalid = 1'b1;
        @(posedge axi_clk);
        lat = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge axi_clk);
            s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0; s_axi_arvalid = 1'b0;
            if (s_axi_bvalid) break;
            lat++;
        end
        check("t5_wr_lat", 32'(lat), 32'd2);
        check("t5_bresp", 32'(s_axi_bresp), 32'd0);
        check("t5_wr_addr", 32'(last_addr), 32'd1);
        for (int i = 0; i < 5; i++) begin
            @(negedge axi_clk);
            check("t5_bvalid_held", 32'(s_axi_bvalid), 32'd1);
            check("t5_aw_w_ready_low", 32'({s_axi_awready, s_axi_wready}), 32'd0);
            check("t5_read_waits", 32'({s_axi_arready, s_axi_rvalid}), 32'd0);
        end
        s_axi_bready = 1'b1;
        @(posedge axi_clk);
        lat = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge axi_clk);
            s_axi_bready = 1'b0;
            if (s_axi_rvalid) break;
            lat++;
        end
        check("t5_rd_lat", 32'(lat), 32'd3);
        check("t5_rdata", s_axi_rdata, 32'h12345678);
        check("t5_rresp", 32'(s_axi_rresp), 32'd0);
        s_axi_rready = 1'b1;
        @(negedge axi_clk);
        s_axi_rready = 1'b0;
        check("t5_ready_back", 32'({s_axi_awready, s_axi_wready, s_axi_arready}), 32'd7);

        // T1: full-strobe write
        base = wr_count;
        do_write(12'h00C, 32'hDEADBEEF, 4'hF, 0, resp, lat);
        check("t1_bresp", 32'(resp), 32'd0);
        check("t1_lat", 32'(lat), 32'd2);
        check("t1_pulses", 32'(wr_count - base), 32'd1);
        check("t1_addr", 32'(last_addr), 32'd3);
        check("t1_data", last_data, 32'hDEADBEEF);

        // T2: read back
        do_read(12'h00C, data, resp, lat);
        check("t2_rdata", data, 32'hDEADBEEF);
        check("t2_rresp", 32'(resp), 32'd0);
        check("t2_lat", 32'(lat), 32'd3);

        // T3: read-modify-write of byte 1
        base = wr_count;
        do_write(12'h00C, 32'h0000AA00, 4'b0010, 0, resp, lat);
        check("t3_bresp", 32'(resp), 32'd0);
        check("t3_lat", 32'(lat), 32'd4);
        check("t3_pulses", 32'(wr_count - base), 32'd1);
        check("t3_addr", 32'(last_addr), 32'd3);
        check("t3_data", last_data, 32'hDEADAAEF);
        do_read(12'h00F, data, resp, lat);
        check("t3_readback", data, 32'hDEADAAEF);

        // Zero strobe: OKAY with no RAM write
        base = wr_count;
        do_write(12'h00C, 32'h55555555, 4'h0, 0, resp, lat);
        check("strb0_bresp", 32'(resp), 32'd0);
        check("strb0_lat", 32'(lat), 32'd1);
        check("strb0_pulses", 32'(wr_count - base), 32'd0);

        // T4: out-of-range decode
        base = wr_count;
        do_write(12'h040, 32'hCAFEF00D, 4'hF, 0, resp, lat);
        check("t4_bresp", 32'(resp), 32'd2);
        check("t4_pulses", 32'(wr_count - base), 32'd0);
        do_read(12'h040, data, resp, lat);
        check("t4_rresp", 32'(resp), 32'd2);
        check("t4_rdata", data, 32'd0);
        check("t4_rd_lat", 32'(lat), 32'd1);
        do_read(12'h03C, data, resp, lat);
        check("t4_top_word_ok", 32'(resp), 32'd0);

        // T6: reset during the RMW wait state
        do_write(12'h008, 32'h11223344, 4'hF, 0, resp, lat);
        base = wr_count;
        @(negedge axi_clk);
        s_axi_awaddr = 12'h008; s_axi_awvalid = 1'b1;
        s_axi_wdata = 32'h000000FF; s_axi_wstrb = 4'b0001; s_axi_wvalid = 1'b1;
        @(posedge axi_clk);
        @(negedge axi_clk);
        s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
        repeat (2) @(negedge axi_clk);
        axi_aresetn = 1'b0;
        repeat (2) @(negedge axi_clk);
        axi_aresetn = 1'b1;
        @(negedge axi_clk);
        check("t6_readies", 32'({s_axi_awready, s_axi_wready, s_axi_arready}), 32'd7);
        check("t6_bvalid", 32'(s_axi_bvalid), 32'd0);
        repeat (5) @(negedge axi_clk);
        check("t6_no_write", 32'(wr_count - base), 32'd0);
        do_read(12'h008, data, resp, lat);
        check("t6_word_kept", data, 32'h11223344);

        check("single_cycle_wr_en", 32'(dbl_count), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
